// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// FSM state encoding, register-index width and the load-use detector.
package hazard_stall_ctrl_pkg;

  localparam int unsigned REG_W          = 5;
  localparam int unsigned MD_LATENCY_DEF = 4;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  // $0 is hard-wired zero, so a load targeting it can never create a dependency.
  function automatic logic load_use(
    input logic             mem_read,
    input logic [REG_W-1:0] rt_ex,
    input logic [REG_W-1:0] rs_id,
    input logic [REG_W-1:0] rt_id
  );
    return mem_read && (rt_ex != '0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-status inputs and pipeline-control outputs of the stall controller.
// slave = the controller, master = the pipeline datapath driving hazard status.
interface hazard_stall_ctrl_if
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned STAT_W = 16
) ();

  logic             MemReadID2EX;
  logic [REG_W-1:0] RtID2EX;
  logic [REG_W-1:0] RsIF2ID;
  logic [REG_W-1:0] RtIF2ID;
  logic             MulDivStartEX;
  logic             BranchTakenID;
  logic             ClearStats;

  logic              PCWrite;
  logic              IF2IDWrite;
  logic              IF2IDFlush;
  logic              ID2EXWrite;
  logic              ID2EXFlush;
  logic              EX2MEMFlush;
  logic              MulDivBusy;
  logic              MulDivDone;
  logic [STAT_W-1:0] StallCycles;

  modport slave (
    input  MemReadID2EX, RtID2EX, RsIF2ID, RtIF2ID, MulDivStartEX, BranchTakenID, ClearStats,
    output PCWrite, IF2IDWrite, IF2IDFlush, ID2EXWrite, ID2EXFlush, EX2MEMFlush,
           MulDivBusy, MulDivDone, StallCycles
  );

  modport master (
    output MemReadID2EX, RtID2EX, RsIF2ID, RtIF2ID, MulDivStartEX, BranchTakenID, ClearStats,
    input  PCWrite, IF2IDWrite, IF2IDFlush, ID2EXWrite, ID2EXFlush, EX2MEMFlush,
           MulDivBusy, MulDivDone, StallCycles
  );

endinterface

// File: rtl/hazard_stall_ctrl_stall_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module stall_counter #(
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [STAT_W-1:0] count
);

  logic [STAT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubble, mul/div freeze of EX and
// taken-branch squash, plus a saturating count of PC-stall cycles.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEF,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned STAT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_stall_ctrl_if.slave bus
);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  logic pc_write, if2id_write, if2id_flush, id2ex_write, id2ex_flush, ex2mem_flush;
  logic md_busy, md_done;
  logic lu, resolve_id, freeze;
  logic [STAT_W-1:0] stall_count;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if2id_write  = 1'b1;
    if2id_flush  = 1'b0;
    id2ex_write  = 1'b1;
    id2ex_flush  = 1'b0;
    ex2mem_flush = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    resolve_id   = 1'b0;
    freeze       = 1'b0;
    lu = load_use(bus.MemReadID2EX, bus.RtID2EX, bus.RsIF2ID, bus.RtIF2ID);

    unique case (state_q)
      RUN: begin
        if (bus.MulDivStartEX) begin
          freeze  = 1'b1;
          cnt_d   = CNT_W'(MD_LATENCY - 2);
          state_d = MD_WAIT;
        end else begin
          resolve_id = 1'b1;
        end
      end
      MD_WAIT: begin
        md_busy = 1'b1;
        if (cnt_q != '0) begin
          freeze = 1'b1;
          cnt_d  = cnt_q - CNT_W'(1);
        end else begin
          md_done    = 1'b1;
          resolve_id = 1'b1;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (freeze) begin
      pc_write     = 1'b0;
      if2id_write  = 1'b0;
      id2ex_write  = 1'b0;
      ex2mem_flush = 1'b1;
    end

    // Load-use outranks the branch: the branch operands are not valid yet,
    // so the redirect is deferred until the load result can be forwarded.
    if (resolve_id) begin
      if (lu) begin
        pc_write    = 1'b0;
        if2id_write = 1'b0;
        id2ex_flush = 1'b1;
      end else if (bus.BranchTakenID) begin
        if2id_flush = 1'b1;
      end
    end

    // Outputs are Mealy, so hold them at reset values for as long as rst is high.
    if (rst) begin
      pc_write     = 1'b1;
      if2id_write  = 1'b1;
      if2id_flush  = 1'b0;
      id2ex_write  = 1'b1;
      id2ex_flush  = 1'b0;
      ex2mem_flush = 1'b0;
      md_busy      = 1'b0;
      md_done      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  stall_counter #(
    .STAT_W(STAT_W)
  ) u_stall_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (~pc_write),
    .clr  (bus.ClearStats),
    .count(stall_count)
  );

  assign bus.PCWrite     = pc_write;
  assign bus.IF2IDWrite  = if2id_write;
  assign bus.IF2IDFlush  = if2id_flush;
  assign bus.ID2EXWrite  = id2ex_write;
  assign bus.ID2EXFlush  = id2ex_flush;
  assign bus.EX2MEMFlush = ex2mem_flush;
  assign bus.MulDivBusy  = md_busy;
  assign bus.MulDivDone  = md_done;
  assign bus.StallCycles = stall_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares every cycle.
module tb_hazard_stall_ctrl;

  localparam int unsigned STAT_W = 4;

  // {PCWrite, IF2IDWrite, IF2IDFlush, ID2EXWrite, ID2EXFlush, EX2MEMFlush, MulDivBusy, MulDivDone}
  localparam logic [7:0] DEF    = 8'b1101_0000;
  localparam logic [7:0] LU     = 8'b0001_1000;
  localparam logic [7:0] BR     = 8'b1111_0000;
  localparam logic [7:0] FRZ    = 8'b0000_0100;
  localparam logic [7:0] FRZ_W  = 8'b0000_0110;
  localparam logic [7:0] REL    = 8'b1101_0011;
  localparam logic [7:0] REL_LU = 8'b0001_1011;
  localparam logic [7:0] REL_BR = 8'b1111_0011;

  typedef struct {
    string             name;
    logic [7:0]        ctl;
    logic [STAT_W-1:0] stat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  hazard_stall_ctrl_if #(.STAT_W(STAT_W)) bus ();

  hazard_stall_ctrl #(
    .MD_LATENCY(4),
    .CNT_W     (3),
    .STAT_W    (STAT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step(input string name, input logic r, input logic rst_mid,
                      input logic mr, input logic [4:0] rt_ex, input logic [4:0] rs_id,
                      input logic [4:0] rt_id, input logic md, input logic br, input logic clr,
                      input logic [7:0] ctl, input int stat);
    exp_t e;
    @(posedge clk);
    #1;
    rst                = r;
    bus.MemReadID2EX  = mr;
    bus.RtID2EX       = rt_ex;
    bus.RsIF2ID       = rs_id;
    bus.RtIF2ID       = rt_id;
    bus.MulDivStartEX = md;
    bus.BranchTakenID = br;
    bus.ClearStats    = clr;
    e.name = name;
    e.ctl  = ctl;
    e.stat = STAT_W'(stat);
    sb_q.push_back(e);
    if (rst_mid) begin
      #1;
      rst = 1'b1;
    end
  endtask

  initial begin : monitor
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {bus.PCWrite, bus.IF2IDWrite, bus.IF2IDFlush, bus.ID2EXWrite,
               bus.ID2EXFlush, bus.EX2MEMFlush, bus.MulDivBusy, bus.MulDivDone};
        checks++;
        if (act !== e.ctl || bus.StallCycles !== e.stat) begin
          errors++;
          $display("FAIL %s: ctl=%b stall=%0d, expected ctl=%b stall=%0d",
                   e.name, act, bus.StallCycles, e.ctl, e.stat);
        end
      end
    end
  end

  initial begin : stimulus
    bus.MemReadID2EX  = 1'b0;
    bus.RtID2EX       = '0;
    bus.RsIF2ID       = '0;
    bus.RtIF2ID       = '0;
    bus.MulDivStartEX = 1'b0;
    bus.BranchTakenID = 1'b0;
    bus.ClearStats    = 1'b0;

    // name          r  rm mr rtex rs rt md br clr ctl stat
    step("rst_hold0", 1, 0, 1, 8, 8, 0, 1, 1, 0, DEF, 0);
    step("rst_hold1", 1, 0, 1, 8, 8, 0, 1, 1, 0, DEF, 0);
    step("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
    step("lu_rs",     0, 0, 1, 8, 8, 0, 0, 0, 0, LU,  0);
    step("after_lu",  0, 0, 0, 8, 8, 0, 0, 0, 0, DEF, 1);
    step("lu_rt",     0, 0, 1, 9, 3, 9, 0, 0, 0, LU,  1);
    step("after_lu2", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 2);
    step("load_r0",   0, 0, 1, 0, 0, 0, 0, 0, 0, DEF, 2);
    step("no_load",   0, 0, 0, 8, 8, 0, 0, 0, 0, DEF, 2);
    step("branch",    0, 0, 0, 0, 0, 0, 0, 1, 0, BR,  2);
    step("lu_branch", 0, 0, 1, 5, 5, 0, 0, 1, 0, LU,  2);
    step("branch_rt", 0, 0, 0, 5, 5, 0, 0, 1, 0, BR,  3);
    step("clear",     0, 0, 0, 0, 0, 0, 0, 0, 1, DEF, 3);
    // mul/div entry ignores a simultaneous load-use and branch
    step("md_entry",  0, 0, 1, 8, 8, 0, 1, 1, 0, FRZ,   0);
    step("md_w1",     0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ_W, 1);
    step("md_w2",     0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ_W, 2);
    step("md_rel",    0, 0, 0, 0, 0, 0, 1, 0, 0, REL,   3);
    step("md_after",  0, 0, 0, 0, 0, 0, 0, 0, 1, DEF,   3);
    step("md2_entry", 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,   0);
    step("md2_w1",    0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ_W, 1);
    step("md2_w2",    0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ_W, 2);
    step("md2_rel_lu",0, 0, 1, 7, 0, 7, 0, 1, 0, REL_LU,3);
    step("md3_entry", 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,   4);
    step("md3_w1",    0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ_W, 5);
    step("md3_w2",    0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ_W, 6);
    step("md3_rel_br",0, 0, 0, 0, 0, 0, 1, 1, 0, REL_BR,7);
    step("md3_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,   7);
    // asynchronous reset during the first wait cycle
    step("md4_entry", 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,   7);
    step("md4_rst",   0, 1, 0, 0, 0, 0, 1, 0, 0, DEF,   0);
    step("md4_rst2",  1, 0, 0, 0, 0, 0, 0, 0, 0, DEF,   0);
    step("post_rst0", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,   0);
    step("post_rst1", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,   0);
    step("post_rst2", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,   0);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat%0d", i), 0, 0, 1, 4, 4, 0, 0, 0, 0, LU, (i > 15) ? 15 : i);
    end
    step("sat_hold",  0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 15);
    step("sat_clear", 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF, 15);
    step("cleared",   0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
    stim_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    wait (stim_done);
    budget = 10;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: pending=%0d, expected pending=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, expected stimulus to complete");
    $fatal(1, "timeout");
  end

endmodule
